// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the write port of a dual-clock FIFO.
// Grants bursts only when the FIFO has room for a full burst plus margin.
module fifo_wr_arbiter #(
  parameter int NREQ    = 2,
  parameter int DW      = 16,
  parameter int UW      = 8,
  parameter int DEPTH   = 256,
  parameter int BURST   = 16,
  parameter int MARGIN  = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   src_valid,
  input  logic [NREQ*DW-1:0] src_data,
  input  logic [NREQ-1:0]   src_last,
  output logic [NREQ-1:0]   src_ready,
  input  logic              fifo_wrfull,
  input  logic [UW-1:0]     fifo_wrusedw,
  output logic              fifo_wrreq,
  output logic [DW-1:0]     fifo_data,
  output logic [NREQ-1:0]   gnt,
  output logic              busy,
  output logic              abort_pulse
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(BURST + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [UW:0] DEPTH_W = (UW+1)'(DEPTH);
  localparam logic [UW:0] NEED_W  = (UW+1)'(BURST + MARGIN);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BURST - 1);
  localparam logic [TW-1:0] IDLE_MAX  = TW'(TIMEOUT - 1);
  localparam logic [NREQ-1:0] ONE = NREQ'(1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [TW-1:0]   idle_q, idle_d;

  logic [UW:0]     free;
  logic            space_ok;
  logic            pick_ok;
  logic [IW-1:0]   pick_idx;
  logic            sel_valid;
  logic            sel_last;
  logic [DW-1:0]   sel_data;
  logic            beat;

  function automatic logic [IW-1:0] wrap_idx(input int v);
    int r;
    r = v % NREQ;
    return r[IW-1:0];
  endfunction

  // wrusedw alone cannot tell empty from full; wrfull decides
  assign free = fifo_wrfull ? '0
              : DEPTH_W - {1'b0, fifo_wrusedw};
  assign space_ok = (free >= NEED_W);

  always_comb begin
    pick_ok  = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_ok &&
          src_valid[wrap_idx(int'(rr_q) + k)]) begin
        pick_ok  = 1'b1;
        pick_idx = wrap_idx(int'(rr_q) + k);
      end
    end
  end

  assign sel_valid = src_valid[gidx_q];
  assign sel_last  = src_last[gidx_q];
  assign sel_data  = src_data[int'(gidx_q)*DW +: DW];

  assign beat = (state_q == S_BURST)
              & sel_valid & ~fifo_wrfull;

  assign gnt       = gnt_q;
  assign busy      = (state_q != S_IDLE);
  assign fifo_data = (|gnt_q) ? sel_data : '0;

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gidx_d      = gidx_q;
    rr_d        = rr_q;
    beat_d      = beat_q;
    idle_d      = idle_q;
    src_ready   = '0;
    fifo_wrreq  = 1'b0;
    abort_pulse = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (space_ok && pick_ok) begin
          gnt_d   = ONE << pick_idx;
          gidx_d  = pick_idx;
          beat_d  = '0;
          idle_d  = '0;
          state_d = S_BURST;
        end
      end
      S_BURST: begin
        src_ready[gidx_q] = ~fifo_wrfull;
        fifo_wrreq        = beat;
        // full-FIFO stalls are not the producer's fault
        if (sel_valid) begin
          idle_d = '0;
        end else if (!fifo_wrfull) begin
          if (idle_q == IDLE_MAX) begin
            abort_pulse = 1'b1;
            state_d     = S_GAP;
          end else begin
            idle_d = idle_q + 1'b1;
          end
        end
        if (beat) begin
          beat_d = beat_q + 1'b1;
          if (sel_last || beat_q == LAST_BEAT) begin
            state_d = S_GAP;
          end
        end
      end
      S_GAP: begin
        gnt_d   = '0;
        rr_d    = wrap_idx(int'(gidx_q) + 1);
        beat_d  = '0;
        idle_d  = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
      idle_q  <= idle_d;
    end
  end

endmodule
